// File: rtl/if_id_stage.sv
// IF/ID pipeline register with immediate-field splitter for the 5-stage RV32I core.
// Captures the fetched PC/instruction, holds on stall, inserts a NOP bubble on flush,
// and presents the raw immediate fields plus a one-hot extension-control code to ID.
// Optional build macro: IFID_PERF_CNT_EN adds saturating stall/flush event counters.
module if_id_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_instr,
  output logic [4:0]      iimm_shamt,
  output logic [11:0]     iimm,
  output logic [11:0]     simm,
  output logic [11:0]     bimm,
  output logic [19:0]     uimm,
  output logic [19:0]     jimm_jal,
  output logic [6:0]      ext_ctrl,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  output logic            id_illegal
);

  // Extension-control one-hot codes shared with the immediate extension unit.
  localparam logic [6:0] ExtShamt = 7'b0000001;
  localparam logic [6:0] ExtItype = 7'b0000010;
  localparam logic [6:0] ExtStype = 7'b0000100;
  localparam logic [6:0] ExtUtype = 7'b0001000;
  localparam logic [6:0] ExtBtype = 7'b0010000;
  localparam logic [6:0] ExtJal   = 7'b0100000;
  localparam logic [6:0] ExtNone  = 7'b0000000;

  // RV32I base opcodes.
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  // funct3 values selecting the shift-immediate forms of OP-IMM.
  localparam logic [2:0] F3Sll = 3'b001;
  localparam logic [2:0] F3Srx = 3'b101;

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      ext_ctrl_d;
  logic            opcode_known;

  // Pipeline register: flush beats stall, stall holds everything, otherwise capture IF.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else if (flush) begin
      // PC is left alone on purpose; only the instruction becomes a bubble.
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (!stall) begin
      valid_q <= if_valid;
      pc_q    <= if_pc;
      instr_q <= if_valid ? if_instr : NOP_INSTR;
    end
  end

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];

  // Map the registered opcode to its extension format and flag unknown opcodes.
  always_comb begin
    ext_ctrl_d   = ExtNone;
    opcode_known = 1'b1;
    case (opcode)
      OpImm: begin
        if ((funct3 == F3Sll) || (funct3 == F3Srx)) begin
          ext_ctrl_d = ExtShamt;
        end else begin
          ext_ctrl_d = ExtItype;
        end
      end
      OpLoad, OpJalr:               ext_ctrl_d = ExtItype;
      OpStore:                      ext_ctrl_d = ExtStype;
      OpLui, OpAuipc:               ext_ctrl_d = ExtUtype;
      OpBranch:                     ext_ctrl_d = ExtBtype;
      OpJal:                        ext_ctrl_d = ExtJal;
      OpReg, OpSystem, OpFence:     ext_ctrl_d = ExtNone;
      default: begin
        ext_ctrl_d   = ExtNone;
        opcode_known = 1'b0;
      end
    endcase
  end

  // Raw immediate fields; sign/zero extension happens downstream in ID.
  always_comb begin
    iimm_shamt = instr_q[24:20];
    iimm       = instr_q[31:20];
    simm       = {instr_q[31:25], instr_q[11:7]};
    bimm       = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
    uimm       = instr_q[31:12];
    jimm_jal   = {instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21]};
  end

  assign id_valid    = valid_q;
  assign id_pc       = pc_q;
  assign id_pc_plus4 = pc_q + PcStep;
  assign id_instr    = instr_q;
  assign ext_ctrl    = ext_ctrl_d;
  // Bubbles and invalid slots never raise illegal-instruction.
  assign id_illegal  = valid_q & ~opcode_known;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating event counters; a flush edge counts only as a flush even if stall is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (flush) begin
        if (flush_cnt_q != 32'hFFFFFFFF) begin
          flush_cnt_q <= flush_cnt_q + 32'd1;
        end
      end else if (stall) begin
        if (stall_cnt_q != 32'hFFFFFFFF) begin
          stall_cnt_q <= stall_cnt_q + 32'd1;
        end
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the IF/ID register and field decode.
module tb_if_id_stage;

  localparam logic [31:0] Nop = 32'h00000013;

  localparam logic [6:0] EShamt = 7'b0000001;
  localparam logic [6:0] EItype = 7'b0000010;
  localparam logic [6:0] EStype = 7'b0000100;
  localparam logic [6:0] EUtype = 7'b0001000;
  localparam logic [6:0] EBtype = 7'b0010000;
  localparam logic [6:0] EJal   = 7'b0100000;
  localparam logic [6:0] ENone  = 7'b0000000;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic [4:0]  iimm_shamt;
  logic [11:0] iimm;
  logic [11:0] simm;
  logic [11:0] bimm;
  logic [19:0] uimm;
  logic [19:0] jimm_jal;
  logic [6:0]  ext_ctrl;
  logic        id_illegal;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_tests;
  int n_fail;

  // Model state: what ID should hold.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  if_id_stage dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr),
    .iimm_shamt  (iimm_shamt),
    .iimm        (iimm),
    .simm        (simm),
    .bimm        (bimm),
    .uimm        (uimm),
    .jimm_jal    (jimm_jal),
    .ext_ctrl    (ext_ctrl),
`ifdef IFID_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .id_illegal  (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-format table from the ISA: opcode -> extension format.
  function automatic logic [6:0] model_ext(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    if (op == 7'h13) return (f3 == 3'd1 || f3 == 3'd5) ? EShamt : EItype;
    if (op == 7'h03 || op == 7'h67) return EItype;
    if (op == 7'h23) return EStype;
    if (op == 7'h37 || op == 7'h17) return EUtype;
    if (op == 7'h63) return EBtype;
    if (op == 7'h6F) return EJal;
    return ENone;
  endfunction

  function automatic logic model_known(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F,
                      7'h33, 7'h73, 7'h0F};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_instr = Nop;
  endtask

  // Apply one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic drive_cycle(input logic s, input logic f, input logic v,
                             input logic [31:0] pc, input logic [31:0] ins);
    stall    = s;
    flush    = f;
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
    if (f) begin
      m_valid = 1'b0;
      m_instr = Nop;
    end else if (!s) begin
      m_valid = v;
      m_pc    = pc;
      m_instr = v ? ins : Nop;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h00112423);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid);
    end
    n_tests++;
    if (id_instr !== Nop) begin
      n_fail++; $display("FAIL reset_instr: got %h want %h", id_instr, Nop);
    end
    n_tests++;
    if (id_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h want 0", id_pc);
    end
    n_tests++;
    if (ext_ctrl !== EItype || iimm !== 12'h0 || id_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_decode: ext=%b iimm=%h ill=%b want ext=%b iimm=0 ill=0",
               ext_ctrl, iimm, id_illegal, EItype);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pass_through();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h100, 32'hFFF10093);
    n_tests++;
    if (id_valid !== 1'b1 || iimm !== 12'hFFF || ext_ctrl !== EItype ||
        id_pc_plus4 !== 32'h104 || id_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL pass_through: v=%b iimm=%h ext=%b pc=%h pc4=%h want 1 fff %b 100 104",
               id_valid, iimm, ext_ctrl, id_pc, id_pc_plus4, EItype);
    end
  endtask

  task automatic test_stall_flush();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h200, 32'h00112423);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'h0080006F);
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'h00112423 ||
          ext_ctrl !== EStype || simm !== 12'h008) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v=%b pc=%h ins=%h ext=%b simm=%h", i, id_valid,
                 id_pc, id_instr, ext_ctrl, simm);
      end
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h400, 32'h0080006F);
    n_tests++;
    if (id_valid !== 1'b0 || id_instr !== Nop || id_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL flush_over_stall: v=%b ins=%h pc=%h want 0 %h 200", id_valid,
               id_instr, id_pc, Nop);
    end
  endtask

  task automatic test_decode_sweep();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h10, 32'h00311093);
    n_tests++;
    if (ext_ctrl !== EShamt || iimm_shamt !== 5'd3) begin
      n_fail++; $display("FAIL slli: ext=%b shamt=%0d want %b 3", ext_ctrl, iimm_shamt, EShamt);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h14, 32'h123450B7);
    n_tests++;
    if (ext_ctrl !== EUtype || uimm !== 20'h12345) begin
      n_fail++; $display("FAIL lui: ext=%b uimm=%h want %b 12345", ext_ctrl, uimm, EUtype);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h18, 32'hFE000EE3);
    n_tests++;
    if (ext_ctrl !== EBtype || bimm !== 12'hFFE) begin
      n_fail++; $display("FAIL beq: ext=%b bimm=%h want %b ffe", ext_ctrl, bimm, EBtype);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h1C, 32'h0080006F);
    n_tests++;
    if (ext_ctrl !== EJal || jimm_jal !== 20'h00004) begin
      n_fail++; $display("FAIL jal: ext=%b jimm=%h want %b 00004", ext_ctrl, jimm_jal, EJal);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h20, 32'h002081B3);
    n_tests++;
    if (ext_ctrl !== ENone || id_illegal !== 1'b0) begin
      n_fail++; $display("FAIL add: ext=%b ill=%b want 0000000 0", ext_ctrl, id_illegal);
    end
  endtask

  task automatic test_illegal_wrap();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h0000007F);
    n_tests++;
    if (ext_ctrl !== ENone || id_illegal !== 1'b1 || id_pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL illegal_wrap: ext=%b ill=%b pc4=%h want 0000000 1 0", ext_ctrl,
               id_illegal, id_pc_plus4);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0000007F);
    n_tests++;
    if (id_instr !== Nop || id_illegal !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_slot: ins=%h ill=%b v=%b want %h 0 0", id_instr, id_illegal,
               id_valid, Nop);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h500, 32'h00311093);
    stall = 1'b1;
    flush = 1'b1;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== Nop) begin
      n_fail++;
      $display("FAIL reset_mid_flush: v=%b pc=%h ins=%h want 0 0 %h", id_valid, id_pc,
               id_instr, Nop);
    end
    @(negedge clk);
    rstn  = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] ops [12];
    logic [31:0] ins;
    logic [31:0] pc;
    logic        s, f, v;
    int          errs;
    ops = '{32'h13, 32'h03, 32'h67, 32'h23, 32'h37, 32'h17, 32'h63, 32'h6F,
            32'h33, 32'h73, 32'h0F, 32'h7F};
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 6) == 0);
      v   = ($urandom_range(0, 4) != 0);
      pc  = {$urandom, 2'b00} | 32'($urandom_range(0, 1) == 0 ? 32'hFFFFFFFC : 32'h0);
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins = {ins[31:7], ops[$urandom_range(0, 11)][6:0]};
      drive_cycle(s, f, v, pc, ins);
      n_tests++;
      if (id_valid !== m_valid || id_pc !== m_pc || id_instr !== m_instr ||
          id_pc_plus4 !== m_pc + 32'd4 || ext_ctrl !== model_ext(m_instr) ||
          iimm !== m_instr[31:20] || iimm_shamt !== m_instr[24:20] ||
          simm !== {m_instr[31:25], m_instr[11:7]} ||
          bimm !== {m_instr[31], m_instr[7], m_instr[30:25], m_instr[11:8]} ||
          uimm !== m_instr[31:12] ||
          jimm_jal !== {m_instr[31], m_instr[19:12], m_instr[20], m_instr[30:21]} ||
          id_illegal !== (m_valid && !model_known(m_instr))) begin
        n_fail++;
        errs++;
        if (errs <= 10) begin
          $display("FAIL random[%0d]: v=%b pc=%h ins=%h ext=%b ill=%b want v=%b pc=%h ins=%h ext=%b ill=%b",
                   i, id_valid, id_pc, id_instr, ext_ctrl, id_illegal, m_valid, m_pc,
                   m_instr, model_ext(m_instr), m_valid && !model_known(m_instr));
        end
      end
    end
  endtask

`ifdef IFID_PERF_CNT_EN
  task automatic test_perf();
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: s=%0d f=%0d want 0 0", perf_stall_cnt, perf_flush_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h40, 32'h00311093);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'h44, 32'h00311093);
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h48, 32'h00311093);
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h4C, 32'h00311093);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h50, 32'h0);
    n_tests++;
    if (perf_stall_cnt !== 32'd5 || perf_flush_cnt !== 32'd2) begin
      n_fail++; $display("FAIL perf_counts: s=%0d f=%0d want 5 2", perf_stall_cnt, perf_flush_cnt);
    end
  endtask
`endif

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_pc    = 32'h0;
    if_instr = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    test_reset();
    test_pass_through();
    test_stall_flush();
    test_decode_sweep();
    test_illegal_wrap();
    test_reset_mid_stall();
    test_random();
`ifdef IFID_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register plus immediate-field splitter for the 5-stage RV32I core.
- Captures the fetched PC/instruction each cycle, holds them on stall, and replaces them with a NOP bubble on flush.
- Drives the raw immediate fields and the 7-bit extension-control code straight into the immediate extension unit in ID.
- Sits between instruction fetch and decode/extension.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).
- RESET_PC, 32'h00000000, id_pc value after reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold current ID contents.
- flush  in  1  branch/jump redirect: insert bubble.
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_pc  in  32  PC of fetched instruction.
- if_instr  in  32  fetched instruction word.
- id_valid  out  1  ID holds a real instruction.
- id_pc  out  32  registered PC.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- id_instr  out  32  registered instruction.
- iimm_shamt  out  5  id_instr[24:20].
- iimm  out  12  id_instr[31:20].
- simm  out  12  {id_instr[31:25], id_instr[11:7]}.
- bimm  out  12  {id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8]}.
- uimm  out  20  id_instr[31:12].
- jimm_jal  out  20  {id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21]}.
- ext_ctrl  out  7  extension-control code for id_instr.
- id_illegal  out  1  id_valid and opcode not recognised.

Behaviour:
- Reset (rstn=0, asynchronous): id_valid=0, id_pc=RESET_PC, id_instr=NOP_INSTR. Derived outputs follow: ext_ctrl=ITYPE, iimm=0, id_illegal=0.
- Per-edge register update, in priority order:
  - flush=1 → id_instr=NOP_INSTR, id_valid=0, id_pc unchanged. Flush overrides stall.
  - else stall=1 → all registers hold.
  - else → id_pc=if_pc. id_instr = if_valid ? if_instr : NOP_INSTR. id_valid=if_valid.
- Latency: exactly 1 cycle from IF inputs to ID outputs. No combinational path from IF inputs to any output.
- All immediate fields, ext_ctrl, id_pc_plus4 and id_illegal are combinational decodes of the registered id_instr/id_pc only.
- ext_ctrl one-hot codes (the EXT_CTRL_* macros in Define.v carry these values):
  - SHAMT=7'b0000001, ITYPE=7'b0000010, STYPE=7'b0000100, UTYPE=7'b0001000, BTYPE=7'b0010000, JAL=7'b0100000, NONE=7'b0000000.
- Opcode (id_instr[6:0]) → ext_ctrl:
  - 0010011 with funct3 001 or 101 → SHAMT; 0010011 with any other funct3 → ITYPE.
  - 0000011, 1100111 → ITYPE.
  - 0100011 → STYPE.
  - 0110111, 0010111 → UTYPE.
  - 1100011 → BTYPE.
  - 1101111 → JAL.
  - 0110011, 1110011, 0001111 → NONE.
  - Anything else → NONE, with id_illegal=id_valid.
- Bubble (NOP_INSTR) decodes as ITYPE with iimm=0. Its id_valid=0, so it has no architectural effect.
- id_pc_plus4 wraps: 32'hFFFFFFFC → 32'h00000000.
- Reset asserted mid-stall or mid-flush: reset wins immediately, without waiting for a clock edge.

Optional Feature:
- IFID_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - Each increments on every rising edge where stall=1 and flush=0 (stall count), or flush=1 (flush count).
  - Both saturate at 32'hFFFFFFFF and reset to 0 on rstn=0.
- IFID_PERF_CNT_EN undefined: ports and counters absent; the rest of the behaviour is identical.

Test Plan:
- Reset: rstn=0 mid-cycle → id_valid=0, id_instr=32'h00000013, id_pc=0, ext_ctrl=7'b0000010, immediately and with no clock edge.
- Pass-through: if_pc=32'h100, if_instr=32'hFFF10093 (addi x1,x2,-1), if_valid=1 → next cycle id_valid=1, iimm=12'hFFF, ext_ctrl=ITYPE, id_pc_plus4=32'h104.
- Stall then flush: load sw 32'h00112423, hold stall=1 for 3 cycles → outputs unchanged, ext_ctrl=STYPE, simm=12'h008. Then assert stall=1 and flush=1 together → id_valid=0, id_instr=NOP.
- Decode sweep:
  - slli 32'h00311093 → SHAMT, iimm_shamt=3.
  - lui 32'h123450B7 → UTYPE, uimm=20'h12345.
  - beq 32'hFE000EE3 → BTYPE, bimm=12'hFFE.
  - jal 32'h0080006F → JAL, jimm_jal=20'h00004.
  - add 32'h002081B3 → NONE, id_illegal=0.
- Illegal and wrap: if_instr=32'h0000007F, if_valid=1, if_pc=32'hFFFFFFFC → ext_ctrl=NONE, id_illegal=1, id_pc_plus4=0. Same word with if_valid=0 → id_instr=NOP, id_illegal=0.
- With IFID_PERF_CNT_EN: 5 stall-only cycles plus 2 flush cycles (one with stall=1) → perf_stall_cnt=5, perf_flush_cnt=2.
